// File: rtl/ysyx_23060059_lsu.sv
// Load/store unit between EXU and WBU: single outstanding bus access, alignment
// and timeout checking, and load data lane select / extension.
module ysyx_23060059_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         receive_valid,
  output logic         receive_ready,
  input  logic         mem_ren,
  input  logic         mem_wen,
  input  logic [2:0]   funct3,
  input  logic [31:0]  addr,
  input  logic [31:0]  store_data,
  input  logic [31:0]  wd_i,
  input  logic [138:0] pass_i,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_we,
  output logic [31:0]  mem_req_addr,
  output logic [31:0]  mem_req_wdata,
  output logic [3:0]   mem_req_wstrb,
  input  logic         mem_resp_valid,
  input  logic [31:0]  mem_resp_rdata,
  input  logic         mem_resp_err,
  output logic         send_valid,
  output logic [31:0]  wd_o,
  output logic [138:0] pass_o,
  output logic         access_fault
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYC);

  state_e         state_q, state_d;
  logic           ren_q, ren_d, wen_q, wen_d, fault_q, fault_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [31:0]    addr_q, addr_d, sdata_q, sdata_d, wdi_q, wdi_d, load_q, load_d;
  logic [138:0]   pass_q, pass_d;
  logic [7:0]     cnt_q, cnt_d;

  logic           isMemOp, misalign, immFault, goBus;
  logic [7:0]     cntInc;
  logic           timeoutHit;
  logic [7:0]     laneByte;
  logic [15:0]    laneHalf;
  logic [31:0]    fmtData;
  logic           fmtBad;

  assign isMemOp    = mem_ren ^ mem_wen;
  assign misalign   = (funct3[1:0] == 2'b01 && addr[0]) ||
                      (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign immFault   = (mem_ren & mem_wen) | (isMemOp & misalign);
  assign goBus      = isMemOp & ~misalign;
  assign cntInc     = cnt_q + 8'd1;
  assign timeoutHit = (cntInc == TimeoutLim);

  // Load formatting works on the live response beat; lane comes from the captured address.
  always_comb begin
    laneByte = mem_resp_rdata[{addr_q[1:0], 3'b000} +: 8];
    laneHalf = addr_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    fmtData  = '0;
    fmtBad   = 1'b0;
    case (funct3_q)
      3'b000:  fmtData = {{24{laneByte[7]}}, laneByte};
      3'b001:  fmtData = {{16{laneHalf[15]}}, laneHalf};
      3'b010:  fmtData = mem_resp_rdata;
      3'b100:  fmtData = {24'd0, laneByte};
      3'b101:  fmtData = {16'd0, laneHalf};
      default: fmtBad  = 1'b1;
    endcase
  end

  always_comb begin
    mem_req_wstrb = 4'b1111;
    mem_req_wdata = sdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        mem_req_wstrb = 4'b0001 << addr_q[1:0];
        mem_req_wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        mem_req_wstrb = 4'b0011 << {addr_q[1], 1'b0};
        mem_req_wdata = {2{sdata_q[15:0]}};
      end
      default: ;
    endcase
    if (!wen_q) mem_req_wstrb = 4'b0000;
  end

  always_comb begin
    state_d  = state_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    wdi_d    = wdi_q;
    pass_d   = pass_q;
    fault_d  = fault_q;
    load_d   = load_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (receive_valid) begin
        ren_d    = mem_ren;
        wen_d    = mem_wen;
        funct3_d = funct3;
        addr_d   = addr;
        sdata_d  = store_data;
        wdi_d    = wd_i;
        pass_d   = pass_i;
        load_d   = '0;
        cnt_d    = '0;
        fault_d  = immFault;
        state_d  = goBus ? REQ : DONE;
      end
      // Timeout wins over a same-cycle grant; a response wins over a same-cycle timeout.
      REQ: begin
        cnt_d = cntInc;
        if (timeoutHit) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cntInc;
        if (mem_resp_valid) begin
          load_d  = fmtData;
          fault_d = mem_resp_err | (ren_q & fmtBad);
          state_d = DONE;
        end else if (timeoutHit) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      sdata_q  <= '0;
      wdi_q    <= '0;
      pass_q   <= '0;
      fault_q  <= 1'b0;
      load_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      wdi_q    <= wdi_d;
      pass_q   <= pass_d;
      fault_q  <= fault_d;
      load_q   <= load_d;
      cnt_q    <= cnt_d;
    end
  end

  assign receive_ready = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign send_valid    = (state_q == DONE);
  assign mem_req_we    = wen_q;
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign wd_o          = (send_valid && !fault_q) ? (ren_q ? load_q : wdi_q) : 32'd0;
  assign pass_o        = send_valid ? {pass_q[138:1], pass_q[0] & ~fault_q} : 139'd0;
  assign access_fault  = send_valid & fault_q;

endmodule

// File: doc/ysyx_23060059_lsu.md
YSYX_23060059_LSU -- requirements
Module: ysyx_23060059_lsu

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the cycles allowed in REQ+RESP before abort (1..255).
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-low; the block SHALL reset on any rising edge where reset==0.
REQ-004 receive_valid  in  1 / receive_ready  out  1  SHALL form the EXU->LSU handshake; transfer when both are 1.
REQ-005 mem_ren, mem_wen  in  1 each; funct3  in  3; addr  in  32; store_data  in  32; wd_i  in  32 (non-load result).
REQ-006 pass_i  in  139  SHALL be {instruction, pc, pc_next, csr_wd, csr_rd[1:0], csreg_en, ecall, ebreak, rd[4:0], reg_en}, with reg_en at bit 0.
REQ-007 mem_req_valid out 1; mem_req_ready in 1; mem_req_we out 1; mem_req_addr out 32; mem_req_wdata out 32; mem_req_wstrb out 4.
REQ-008 mem_resp_valid in 1; mem_resp_rdata in 32; mem_resp_err in 1.
REQ-009 send_valid out 1; wd_o out 32; pass_o out 139; access_fault out 1. These SHALL drive the write-back stage, which samples them when send_valid==1 and has no ready.

Function
REQ-010 FSM states SHALL be IDLE, REQ, RESP, DONE; receive_ready SHALL be 1 only in IDLE.
REQ-011 IDLE with receive_valid: all inputs SHALL be captured into internal registers.
- Next state is REQ if (mem_ren xor mem_wen) and the access is aligned.
- Otherwise next state is DONE.
REQ-012 Misalignment SHALL be: halfword (funct3[1:0]==01) with addr[0]==1, or word (funct3[1:0]==10) with addr[1:0]!=0.
REQ-013 Misalignment, or mem_ren and mem_wen both 1, SHALL cause DONE with access_fault=1 and no bus request.
REQ-014 REQ: mem_req_valid SHALL be 1, with addr/we/wdata/wstrb held stable; on mem_req_ready==1 the next state SHALL be RESP.
REQ-015 mem_req_addr SHALL be {addr[31:2],2'b00}; mem_req_we SHALL equal the captured mem_wen.
REQ-016 Store wstrb and wdata by funct3:
- SB: wstrb=4'b0001<<addr[1:0], wdata=byte replicated x4.
- SH: wstrb=4'b0011<<{addr[1],1'b0}, wdata=halfword replicated x2.
- SW: wstrb=4'b1111, wdata=store_data.
REQ-017 Loads SHALL drive wstrb=4'b0000.
REQ-018 RESP: on mem_resp_valid the next state SHALL be DONE. mem_resp_valid outside RESP SHALL be ignored.
REQ-019 Load data SHALL be taken from lane addr[1:0] (byte) or addr[1] (half) and formatted by funct3:
- 000 LB: sign-extend.
- 001 LH: sign-extend.
- 010 LW: full word.
- 100 LBU: zero-extend.
- 101 LHU: zero-extend.
- Any other load funct3: access_fault.
REQ-020 In DONE, wd_o SHALL be the formatted load data for a load, else wd_i.
REQ-021 A timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or RESP. On reaching TIMEOUT_CYC the next state SHALL be DONE with access_fault=1.
REQ-022 mem_resp_err==1 with mem_resp_valid SHALL set access_fault=1.
REQ-023 DONE SHALL last exactly one cycle with send_valid=1, then return to IDLE.
REQ-024 Outside DONE, send_valid SHALL be 0; wd_o, pass_o and access_fault SHALL be valid only while send_valid==1.
REQ-025 pass_o SHALL equal the captured pass_i, except bit 0 (reg_en) SHALL be forced 0 when access_fault=1; on fault, wd_o SHALL be 0.
REQ-026 Latency from the handshake cycle t:
- Non-memory: send_valid at t+1.
- Memory access with ready at t+1 and response at t+2: send_valid at t+3.

Reset
REQ-027 With reset==0, the FSM SHALL go to IDLE, the timeout counter SHALL clear, and all registered outputs SHALL be 0. Combinational outputs follow from IDLE: receive_ready=1, mem_req_valid=0, send_valid=0.
REQ-028 Reset during REQ/RESP SHALL drop the transaction without a send_valid pulse; responses arriving after reset SHALL be ignored.

Verification
REQ-029 Non-memory: receive_valid with wd_i=0x1234, reg_en=1 -> send_valid one cycle later, wd_o=0x1234, pass_o==pass_i, no mem_req_valid.
REQ-030 LB: addr=0x80000003, rdata=0x80FF0000 -> wstrb=0, mem_req_addr=0x80000000, wd_o=0xFFFFFF80. LHU: addr=0x2, rdata=0xBEEF0000 -> wd_o=0x0000BEEF.
REQ-031 SB: addr=0x1001, store_data=0xAB -> wstrb=4'b0010, wdata=0xABABABAB, mem_req_we=1. SW with mem_req_ready held 0 for 5 cycles -> request held stable throughout.
REQ-032 LW: addr=0x2 -> no bus request, send_valid at t+1, access_fault=1, pass_o[0]=0, wd_o=0.
REQ-033 TIMEOUT_CYC=4, mem_resp_valid never asserted -> send_valid with access_fault=1 after 4 cycles in REQ/RESP. mem_resp_err=1 -> access_fault=1.
REQ-034 reset=0 asserted in RESP -> IDLE next cycle, no send_valid; a late mem_resp_valid is ignored, and the next transaction completes normally.
